rv32i_prog_loader: RTL and testbench



---
 rtl/rv32i_prog_loader.sv | 123 ++++++++++++
 tb/tb_rv32i_prog_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rv32i_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_prog_loader
// Brief    : Framed byte-stream loader for rv32i instruction memory; holds the
//            core until a frame with a valid XOR checksum has been written.
// Revision : 1.0
// ============================================================================
module rv32i_prog_loader #(
  parameter int          ADDR_W = 6,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CNT  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t            r_state;
  logic [7:0]        r_count;
  logic [7:0]        r_csum;
  logic [1:0]        r_idx;
  logic [23:0]       r_word;
  logic [ADDR_W-1:0] r_wptr;

  // The loader never back-pressures the stream.
  assign byte_ready = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= 8'd0;
      r_csum    <= 8'd0;
      r_idx     <= 2'd0;
      r_word    <= 24'd0;
      r_wptr    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (byte_valid) begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (byte_data == SYNC) begin
              r_state   <= S_CNT;
              core_hold <= 1'b1;
              done      <= 1'b0;
              err       <= 1'b0;
            end
          end
          S_CNT: begin
            r_count <= byte_data;
            r_csum  <= byte_data;
            if (byte_data == 8'd0) begin
              r_state <= S_ERR;
              err     <= 1'b1;
            end else begin
              r_state <= S_ADDR;
            end
          end
          S_ADDR: begin
            r_wptr  <= ADDR_W'(byte_data);
            r_csum  <= r_csum ^ byte_data;
            r_idx   <= 2'd0;
            r_state <= S_DATA;
          end
          S_DATA: begin
            r_csum <= r_csum ^ byte_data;
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              // Little-endian: the first byte of the word ends up in bits 7:0.
              mem_we    <= 1'b1;
              mem_addr  <= r_wptr;
              mem_wdata <= {byte_data, r_word};
              r_wptr    <= r_wptr + 1'b1;
              r_count   <= r_count - 8'd1;
              if (r_count == 8'd1)
                r_state <= S_CSUM;
            end else begin
              r_word <= {byte_data, r_word[23:8]};
            end
          end
          S_CSUM: begin
            if (byte_data == r_csum) begin
              r_state   <= S_DONE;
              done      <= 1'b1;
              err       <= 1'b0;
              core_hold <= 1'b0;
            end else begin
              r_state   <= S_ERR;
              done      <= 1'b0;
              err       <= 1'b1;
              core_hold <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_prog_loader
// Brief    : Directed self-checking bench for the program loader.
// Revision : 1.0
// ============================================================================
module tb_rv32i_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0]  wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_n = 0;

  rv32i_prog_loader #(.ADDR_W(6), .SYNC(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Log every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_we && wr_n < 64) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_n = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Sends n bytes held in v, first byte in the most significant used position.
  task automatic send_list(input logic [8*16-1:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_data  = v[8*(n-1-i) +: 8];
      @(negedge clk);
      byte_valid = 1'b0;
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    check({tag, " done"}, {31'd0, done}, {31'd0, d});
    check({tag, " err"}, {31'd0, err}, {31'd0, e});
    check({tag, " core_hold"}, {31'd0, core_hold}, {31'd0, h});
  endtask

  localparam logic [8*16-1:0] FRAME1 =
    {8'hA5, 8'h02, 8'h00, 8'h00, 8'h20, 8'h22, 8'h00, 8'h00, 8'h28, 8'h43, 8'h04, 8'h6F};

  int base;

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);

    check("reset byte_ready", {31'd0, byte_ready}, 32'd1);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", {26'd0, mem_addr}, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check_status("reset", 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    idle(2);

    // Case 1: two-word frame, back-to-back.
    base = wr_n;
    send_list(FRAME1, 12, 0);
    idle(2);
    check("c1 writes", wr_n - base, 2);
    check("c1 addr0", {26'd0, wr_addr[base]}, 32'd0);
    check("c1 data0", wr_data[base], 32'h00222000);
    check("c1 addr1", {26'd0, wr_addr[base+1]}, 32'd1);
    check("c1 data1", wr_data[base+1], 32'h04432800);
    check_status("c1", 1'b1, 1'b0, 1'b0);
    check("c1 mem_we low", {31'd0, mem_we}, 32'd0);

    // Case 2: bad checksum, then recovery with a valid frame.
    base = wr_n;
    send_list({8'hA5, 8'h02, 8'h00, 8'h00, 8'h20, 8'h22, 8'h00,
               8'h00, 8'h28, 8'h43, 8'h04, 8'h6E}, 12, 0);
    idle(2);
    check("c2 writes", wr_n - base, 2);
    check_status("c2 bad", 1'b0, 1'b1, 1'b1);
    send_list(FRAME1, 12, 0);
    idle(2);
    check_status("c2 reload", 1'b1, 1'b0, 1'b0);

    // Case 3: single word at address 47 with gaps between bytes.
    base = wr_n;
    send_list({8'hA5, 8'h01, 8'h2F, 8'h00, 8'h60, 8'hAE, 8'h01, 8'hE1}, 8, 1);
    idle(2);
    check("c3 writes", wr_n - base, 1);
    check("c3 addr", {26'd0, wr_addr[base]}, 32'd47);
    check("c3 data", wr_data[base], 32'h01AE6000);
    check_status("c3", 1'b1, 1'b0, 1'b0);

    // Case 4: address wrap 63 -> 0. XOR of 02,3F and the payload is 3D.
    base = wr_n;
    send_list({8'hA5, 8'h02, 8'h3F, 8'h11, 8'h11, 8'h11, 8'h11,
               8'h22, 8'h22, 8'h22, 8'h22, 8'h3D}, 12, 0);
    idle(2);
    check("c4 writes", wr_n - base, 2);
    check("c4 addr0", {26'd0, wr_addr[base]}, 32'd63);
    check("c4 data0", wr_data[base], 32'h11111111);
    check("c4 addr1", {26'd0, wr_addr[base+1]}, 32'd0);
    check("c4 data1", wr_data[base+1], 32'h22222222);
    check_status("c4", 1'b1, 1'b0, 1'b0);

    // Case 5: zero count errors at once; garbage before sync is ignored.
    base = wr_n;
    send_list({8'hA5, 8'h00}, 2, 0);
    idle(2);
    check("c5 writes", wr_n - base, 0);
    check_status("c5 zero", 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    base = wr_n;
    send_list({8'h00, 8'hFF, 8'h5A}, 3, 0);
    send_list(FRAME1, 12, 0);
    idle(2);
    check("c5 writes after garbage", wr_n - base, 2);
    check("c5 data1", wr_data[base+1], 32'h04432800);
    check_status("c5 load", 1'b1, 1'b0, 1'b0);

    // Case 6: reset after the second data byte abandons the frame.
    base = wr_n;
    send_list({8'hA5, 8'h01, 8'h05, 8'h11, 8'h22}, 5, 0);
    rst = 1'b1;
    #1;
    check("c6 mem_we", {31'd0, mem_we}, 32'd0);
    check("c6 mem_addr", {26'd0, mem_addr}, 32'd0);
    check("c6 mem_wdata", mem_wdata, 32'd0);
    check_status("c6 rst", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    check("c6 no write", wr_n - base, 0);
    send_list(FRAME1, 12, 0);
    idle(2);
    check("c6 reload writes", wr_n - base, 2);
    check("c6 data0", wr_data[base], 32'h00222000);
    check("c6 data1", wr_data[base+1], 32'h04432800);
    check_status("c6 reload", 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
